// File: rtl/reg_pipe_n.sv
// reg_pipe_n: WIDTH-bit, DEPTH-stage register pipeline with a valid/ready
// handshake on both sides. Stalled words hold in place, and bubbles collapse
// forward. It also has a synchronous flush (CLR) and an occupancy count.
// Optional feature macro: REG_PIPE_STALL_CNT_EN. When it is defined, the block
// adds a saturating 16-bit STALL_CNT output that counts the cycles where the
// output is stalled.

// One pipeline stage: a valid bit plus a data word.
module reg_pipe_stage #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             ld,
  input  logic             up_v,
  input  logic [WIDTH-1:0] up_d,
  output logic             v,
  output logic [WIDTH-1:0] d
);

  // Data only moves on a valid load, so the last stage keeps its word when the pipe drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v <= 1'b0;
      d <= '0;
    end else if (clr) begin
      v <= 1'b0;
    end else if (ld) begin
      v <= up_v;
      if (up_v) d <= up_d;
    end
  end

endmodule

module reg_pipe_n #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 3
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic                       CLR,
  input  logic                       IN_VALID,
  output logic                       IN_READY,
  input  logic [WIDTH-1:0]           D_IN,
  output logic                       OUT_VALID,
  input  logic                       OUT_READY,
  output logic [WIDTH-1:0]           D_OUT,
  output logic [$clog2(DEPTH+1)-1:0] OCCUPANCY
`ifdef REG_PIPE_STALL_CNT_EN
  ,
  output logic [15:0]                STALL_CNT
`endif
);

  localparam int OCC_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0]            v;
  logic [DEPTH-1:0]            r;
  logic [DEPTH-1:0][WIDTH-1:0] d;

  // Ready ripples back from the consumer. An empty stage is always ready,
  // and that is what makes bubbles collapse.
  always_comb begin
    r = '0;
    r[DEPTH-1] = ~v[DEPTH-1] | OUT_READY;
    for (int k = DEPTH-2; k >= 0; k--) r[k] = ~v[k] | r[k+1];
  end

  assign IN_READY  = r[0] & ~CLR;
  assign OUT_VALID = v[DEPTH-1];
  assign D_OUT     = d[DEPTH-1];

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    if (k == 0) begin : g_head
      reg_pipe_stage #(.WIDTH(WIDTH)) u_stage (
        .clk(CLK), .rst_n(RST_N), .clr(CLR), .ld(r[k]),
        .up_v(IN_VALID), .up_d(D_IN), .v(v[k]), .d(d[k])
      );
    end else begin : g_body
      reg_pipe_stage #(.WIDTH(WIDTH)) u_stage (
        .clk(CLK), .rst_n(RST_N), .clr(CLR), .ld(r[k]),
        .up_v(v[k-1]), .up_d(d[k-1]), .v(v[k]), .d(d[k])
      );
    end
  end

  // Occupancy is the popcount of the registered valid bits.
  always_comb begin
    OCCUPANCY = '0;
    for (int k = 0; k < DEPTH; k++) OCCUPANCY = OCCUPANCY + OCC_W'(v[k]);
  end

`ifdef REG_PIPE_STALL_CNT_EN
  // Count the edges where the output is stalled. The count saturates at
  // all-ones, and a flush takes priority over an increment.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)                                          STALL_CNT <= '0;
    else if (CLR)                                        STALL_CNT <= '0;
    else if (OUT_VALID && !OUT_READY && STALL_CNT != 16'hFFFF) STALL_CNT <= STALL_CNT + 16'd1;
  end
`endif

endmodule
